mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the PC/fetch stage, the LSU and the memory.
- Sequences each access through a fixed-latency FSM and gives LS priority, with a starvation bound for IF.
- Outputs from this block drive the fetch stall and the LSU stall.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-ported unified instruction/data memory.
// Load/store wins over fetch, except that fetch is forced through after
// MAX_LS_RUN back-to-back load/store grants. Each access runs a fixed-latency
// sequence, and only one access is outstanding at a time.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,   // grant cycle to read-data-valid, 1..7
    parameter int MAX_LS_RUN = 4    // consecutive LS grants while IF waits, 1..15
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,

    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_ls_rdata,

    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic [31:0] i_mem_rdata,

    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_LS_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT);
    localparam logic [3:0] RUN_MAX  = 4'(MAX_LS_RUN);

    state_t      state_q,   state_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        ls_wren_q, ls_wren_d;   // remembers whether the LS access is a store

    logic        ls_win;
    logic        if_win;
    logic        done;

    // Arbitration decision and end-of-access detection.
    always_comb begin
        ls_win = 1'b0;
        if_win = 1'b0;
        done   = 1'b0;
        if (state_q == ST_IDLE) begin
            ls_win = i_ls_req && !(i_if_req && (run_cnt_q == RUN_MAX));
            if_win = i_if_req && !ls_win;
        end else begin
            done = (lat_cnt_q == LAT_LAST);
        end
    end

    // Next-state, latency counter and starvation counter.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        run_cnt_d = run_cnt_q;
        ls_wren_d = ls_wren_q;

        case (state_q)
            ST_IDLE: begin
                if (ls_win) begin
                    state_d   = ST_LS_WAIT;
                    lat_cnt_d = 3'd1;
                    ls_wren_d = i_ls_wren;
                end else if (if_win) begin
                    state_d   = ST_IF_WAIT;
                    lat_cnt_d = 3'd1;
                end
            end
            ST_IF_WAIT, ST_LS_WAIT: begin
                if (done) begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = 3'd0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                lat_cnt_d = 3'd0;
            end
        endcase

        // The run only counts while fetch is actually waiting.
        if (!i_if_req || if_win) begin
            run_cnt_d = 4'd0;
        end else if (ls_win && (run_cnt_q < RUN_MAX)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    // State registers; reset drops any outstanding access.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= 3'd0;
            run_cnt_q <= 4'd0;
            ls_wren_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            run_cnt_q <= run_cnt_d;
            ls_wren_q <= ls_wren_d;
        end
    end

    // Requester handshakes and memory bus; a cycle whose edge resets shows nothing.
    always_comb begin
        o_if_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = 32'd0;
        o_ls_gnt    = 1'b0;
        o_ls_rvalid = 1'b0;
        o_ls_rdata  = 32'd0;
        o_mem_req   = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        o_mem_bmask = 4'd0;

        if (!i_reset) begin
            if (ls_win) begin
                o_ls_gnt    = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_wren  = i_ls_wren;
                o_mem_addr  = i_ls_addr;
                o_mem_wdata = i_ls_wdata;
                o_mem_bmask = i_ls_bmask;
            end else if (if_win) begin
                o_if_gnt    = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_addr  = i_if_addr;
                o_mem_bmask = 4'hF;
            end

            if (done && (state_q == ST_IF_WAIT)) begin
                o_if_rvalid = 1'b1;
                o_if_rdata  = i_mem_rdata;
            end
            if (done && (state_q == ST_LS_WAIT)) begin
                o_ls_rvalid = 1'b1;
                o_ls_rdata  = ls_wren_q ? 32'd0 : i_mem_rdata;
            end
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2 and one at
// MEM_LAT=1, both with MAX_LS_RUN=4. Inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_reset;

    // Instance with MEM_LAT=2
    logic        if_req, ls_req, ls_wren;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_wren, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;

    // Instance with MEM_LAT=1
    logic        d1_if_req, d1_ls_req;
    logic [31:0] d1_mem_rdata;
    logic        d1_if_gnt, d1_if_rvalid, d1_ls_gnt, d1_ls_rvalid;
    logic [31:0] d1_if_rdata, d1_ls_rdata;
    logic        d1_mem_req, d1_mem_wren, d1_busy;
    logic [31:0] d1_mem_addr, d1_mem_wdata;
    logic [3:0]  d1_mem_bmask;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter #(.MEM_LAT(2), .MAX_LS_RUN(4)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_wren(ls_wren), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask),
        .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
        .o_mem_req(mem_req), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata),
        .o_busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .MAX_LS_RUN(4)) dut1 (
        .i_clk(clk), .i_reset(i_reset),
        .i_if_req(d1_if_req), .i_if_addr(32'h0000_0400),
        .o_if_gnt(d1_if_gnt), .o_if_rvalid(d1_if_rvalid), .o_if_rdata(d1_if_rdata),
        .i_ls_req(d1_ls_req), .i_ls_wren(1'b0), .i_ls_addr(32'h0000_4000),
        .i_ls_wdata(32'd0), .i_ls_bmask(4'h0),
        .o_ls_gnt(d1_ls_gnt), .o_ls_rvalid(d1_ls_rvalid), .o_ls_rdata(d1_ls_rdata),
        .o_mem_req(d1_mem_req), .o_mem_wren(d1_mem_wren), .o_mem_addr(d1_mem_addr),
        .o_mem_wdata(d1_mem_wdata), .o_mem_bmask(d1_mem_bmask), .i_mem_rdata(d1_mem_rdata),
        .o_busy(d1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic exp_ls;

    initial begin
        i_reset = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; ls_wren = 1'b0;
        if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_bmask = 4'd0;
        mem_rdata = 32'd0;
        d1_if_req = 1'b0; d1_ls_req = 1'b0; d1_mem_rdata = 32'd0;
        step(); step();
        i_reset = 1'b0;

        // Reset state
        sample();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_gnt", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 32'd0);
        $display("txn reset: busy=%0d mem_req=%0d", busy, mem_req);
        step();

        // Single fetch, IF held high to observe the next grant slot
        if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h0050_0093;
        sample();
        chk("if_gnt_c0", 32'(if_gnt), 32'd1);
        chk("if_mem_req_c0", 32'(mem_req), 32'd1);
        chk("if_mem_addr_c0", mem_addr, 32'h100);
        chk("if_mem_bmask_c0", 32'(mem_bmask), 32'hF);
        chk("if_mem_wren_c0", 32'(mem_wren), 32'd0);
        step();
        sample();
        chk("if_idle_bus_c1", 32'({if_gnt, mem_req, if_rvalid}), 32'd0);
        chk("if_rdata_c1", if_rdata, 32'd0);
        chk("if_busy_c1", 32'(busy), 32'd1);
        step();
        sample();
        chk("if_rvalid_c2", 32'(if_rvalid), 32'd1);
        chk("if_rdata_c2", if_rdata, 32'h0050_0093);
        step();
        sample();
        chk("if_gnt_c3", 32'(if_gnt), 32'd1);
        $display("txn fetch: addr=0x100 rdata=%h", 32'h0050_0093);
        step();
        if_req = 1'b0;
        step(); step();

        // Simultaneous requests: load wins, fetch follows at G+3
        if_req = 1'b1; if_addr = 32'h104;
        ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h2000; mem_rdata = 32'hDEAD_BEEF;
        sample();
        chk("both_ls_gnt", 32'(ls_gnt), 32'd1);
        chk("both_if_gnt", 32'(if_gnt), 32'd0);
        chk("both_mem_addr", mem_addr, 32'h2000);
        step();
        ls_req = 1'b0;
        sample();
        chk("both_gnt_g1", 32'({if_gnt, ls_gnt}), 32'd0);
        step();
        sample();
        chk("both_ls_rvalid_g2", 32'(ls_rvalid), 32'd1);
        chk("both_ls_rdata_g2", ls_rdata, 32'hDEAD_BEEF);
        chk("both_if_rvalid_g2", 32'(if_rvalid), 32'd0);
        step();
        sample();
        chk("both_if_gnt_g3", 32'(if_gnt), 32'd1);
        chk("both_if_addr_g3", mem_addr, 32'h104);
        $display("txn load+fetch: ls rdata=%h, if granted at G+3", 32'hDEAD_BEEF);
        step();
        if_req = 1'b0;
        step(); step();

        // Store: bus carries the payload for exactly one cycle
        ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h2004;
        ls_wdata = 32'h1234_5678; ls_bmask = 4'b0011; mem_rdata = 32'hFFFF_FFFF;
        sample();
        chk("st_gnt", 32'(ls_gnt), 32'd1);
        chk("st_mem_wren", 32'(mem_wren), 32'd1);
        chk("st_mem_addr", mem_addr, 32'h2004);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("st_mem_bmask", 32'(mem_bmask), 32'h3);
        step();
        ls_req = 1'b0; ls_wren = 1'b0;
        sample();
        chk("st_bus_g1", 32'({mem_req, mem_wren, mem_bmask}), 32'd0);
        chk("st_addr_g1", mem_addr | mem_wdata, 32'd0);
        chk("st_rvalid_g1", 32'(ls_rvalid), 32'd0);
        step();
        sample();
        chk("st_rvalid_g2", 32'(ls_rvalid), 32'd1);
        chk("st_rdata_g2", ls_rdata, 32'd0);
        $display("txn store: addr=0x2004 wdata=0x12345678 bmask=3");
        step();

        // Starvation bound: both held, expect L L L L I L L L L I
        ls_req = 1'b1; ls_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h200;
        for (int k = 0; k < 10; k++) begin
            exp_ls = !((k == 4) || (k == 9));
            sample();
            chk($sformatf("run_ls_gnt_%0d", k), 32'(ls_gnt), 32'(exp_ls));
            chk($sformatf("run_if_gnt_%0d", k), 32'(if_gnt), 32'(!exp_ls));
            $display("txn run slot %0d: ls_gnt=%0d if_gnt=%0d", k, ls_gnt, if_gnt);
            step(); step(); step();
        end
        ls_req = 1'b0; if_req = 1'b0;
        step();

        // Reset one cycle after a load grant drops the access
        ls_req = 1'b1; ls_addr = 32'h2008; mem_rdata = 32'hCAFE_F00D;
        sample();
        chk("rst_ls_gnt", 32'(ls_gnt), 32'd1);
        step();
        ls_req = 1'b0; i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        sample();
        chk("rst_no_rvalid", 32'(ls_rvalid), 32'd0);
        chk("rst_busy_after", 32'(busy), 32'd0);
        chk("rst_outs_after", 32'({mem_req, if_gnt, ls_gnt, if_rvalid}), 32'd0);
        chk("rst_rdata_after", ls_rdata | mem_addr, 32'd0);
        step();
        if_req = 1'b1; if_addr = 32'h300;
        sample();
        chk("rst_if_gnt", 32'(if_gnt), 32'd1);
        chk("rst_if_addr", mem_addr, 32'h300);
        $display("txn reset mid-access: dropped, fetch granted after");
        step();
        if_req = 1'b0;
        step(); step();

        // MEM_LAT=1 instance, alternating LS / IF every 2 cycles
        for (int k = 0; k < 6; k++) begin
            exp_ls = (k % 2 == 0);
            d1_ls_req = exp_ls;
            d1_if_req = !exp_ls;
            d1_mem_rdata = 32'hA000_0000 + 32'(k);
            sample();
            chk($sformatf("alt_gnt_%0d", k), 32'({d1_ls_gnt, d1_if_gnt}), exp_ls ? 32'd2 : 32'd1);
            chk($sformatf("alt_rv_g_%0d", k), 32'({d1_ls_rvalid, d1_if_rvalid}), 32'd0);
            step();
            d1_ls_req = 1'b0; d1_if_req = 1'b0;
            sample();
            chk($sformatf("alt_rv_%0d", k), 32'({d1_ls_rvalid, d1_if_rvalid}), exp_ls ? 32'd2 : 32'd1);
            chk($sformatf("alt_gnt_r_%0d", k), 32'({d1_ls_gnt, d1_if_gnt}), 32'd0);
            chk($sformatf("alt_rdata_%0d", k), exp_ls ? d1_ls_rdata : d1_if_rdata, 32'hA000_0000 + 32'(k));
            chk($sformatf("alt_rdata_other_%0d", k), exp_ls ? d1_if_rdata : d1_ls_rdata, 32'd0);
            $display("txn lat1 slot %0d: %s rdata=%h", k, exp_ls ? "ls" : "if", 32'hA000_0000 + 32'(k));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
